dmem_arbiter: RTL

//  Two-requester arbiter/sequencer for the 1K x 32 data memory (sync write, async read).

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/rr_pick2.sv | 23 ++
 rtl/dmem_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port count, width defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int NUM_PORTS  = 2;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way requester pick used when the arbiter leaves IDLE.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req (per-port request), rr_ptr (preferred port on a tie), winner (chosen port).
module rr_pick2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    case (req)
      2'b10:   winner = 1'b1;
      // Tie: fixed mode always favours port 0, otherwise follow the pointer.
      2'b11:   winner = FIXED_PRIO ? 1'b0 : rr_ptr;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a sync-write, async-read data memory; single-word req/ack.
// Latency: req sampled at edge E0 -> SERVE in cycle 1 -> one-cycle ack (with err/rdata) in cycle 2.
// Backpressure: requester holds req until its ack; the other port waits, served back-to-back from RESP.
// Ports: clk/rst_n; req_i/we_i per port; addr0_i/addr1_i, wdata0_i/wdata1_i requester side;
//        ack_o/err_o/rdata_o response; mem_addr_o/mem_wdata_o/mem_we_o/mem_rdata_i memory side.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIXED_PRIO = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0] we_i,
  input  logic [31:0]          addr0_i,
  input  logic [31:0]          addr1_i,
  input  logic [DATA_W-1:0]    wdata0_i,
  input  logic [DATA_W-1:0]    wdata1_i,
  output logic [NUM_PORTS-1:0] ack_o,
  output logic                 err_o,
  output logic [DATA_W-1:0]    rdata_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [DATA_W-1:0]    mem_wdata_o,
  output logic                 mem_we_o,
  input  logic [DATA_W-1:0]    mem_rdata_i
);

  state_t            state, state_nxt;
  logic              gnt, gnt_nxt;
  logic              rr_ptr, rr_ptr_nxt;
  logic              winner;
  logic [31:0]       addr_sel;
  logic              in_range;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  rr_pick2 #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_pick (
    .req    (req_i),
    .rr_ptr (rr_ptr),
    .winner (winner)
  );

  // The memory port always follows the granted requester; it only matters in SERVE.
  assign addr_sel    = gnt ? addr1_i : addr0_i;
  assign in_range    = (addr_sel[31:ADDR_W] == '0);
  assign mem_addr_o  = addr_sel[ADDR_W-1:0];
  assign mem_wdata_o = gnt ? wdata1_i : wdata0_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // mem_we_o and ack_o are decoded from state so a reset removes them immediately.
  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    rr_ptr_nxt = rr_ptr;
    mem_we_o   = 1'b0;
    ack_o      = '0;
    case (state)
      IDLE: begin
        if (|req_i) begin
          gnt_nxt    = winner;
          rr_ptr_nxt = ~winner;
          state_nxt  = SERVE;
        end
      end
      SERVE: begin
        mem_we_o  = we_i[gnt] & in_range;
        state_nxt = RESP;
      end
      RESP: begin
        ack_o[gnt] = 1'b1;
        // Hand straight over to the waiting port; the acked port's req is ignored here.
        if (req_i[~gnt]) begin
          gnt_nxt    = ~gnt;
          rr_ptr_nxt = gnt;
          state_nxt  = SERVE;
        end else begin
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the response on the edge that ends SERVE; out-of-range reads return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == SERVE) begin
      rdata_q <= in_range ? mem_rdata_i : '0;
      err_q   <= ~in_range;
    end
  end

  assign rdata_o = rdata_q;
  assign err_o   = err_q & (state == RESP);

endmodule
